// File: rtl/itcm_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : itcm_arbiter_if
//  Brief    : Fetch, loader and single-port ITCM bus bundle for itcm_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface itcm_arbiter_if #(
    parameter int AW = 14
);
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_rvalid;
    logic [63:0]   fetch_rdata;
    logic          fetch_rready;
    logic          flush;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [63:0]   ld_wdata;
    logic [7:0]    ld_wstrb;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [63:0]   ld_rdata;

    logic          ram_en;
    logic          ram_we;
    logic [7:0]    ram_wstrb;
    logic [AW-1:0] ram_addr;
    logic [63:0]   ram_wdata;
    logic [63:0]   ram_rdata;

    // Arbiter side
    modport slave (
        input  fetch_req, fetch_addr, fetch_rready, flush,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_wstrb,
        input  ram_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output ram_en, ram_we, ram_wstrb, ram_addr, ram_wdata
    );

    // Requesters and RAM side
    modport master (
        output fetch_req, fetch_addr, fetch_rready, flush,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_wstrb,
        output ram_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  ram_en, ram_we, ram_wstrb, ram_addr, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/itcm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : itcm_arbiter
//  Brief    : Arbitrates fetch and loader onto a single-port 64-bit ITCM with
//             fetch anti-starvation, a 1-entry fetch hold buffer and flush.
//  Revision : 1.0 - initial release
// ============================================================================
module itcm_arbiter #(
    parameter int AW      = 14,
    parameter int MAXWAIT = 4
) (
    input  wire            clk_i,
    input  wire            rst_i,
    itcm_arbiter_if.slave  bus
);
    localparam logic [2:0] c_MAXWAIT = 3'(MAXWAIT);

    logic [2:0]  starve_q, starve_d;
    logic        fetch_inflight_q, fetch_inflight_d;
    logic        ld_inflight_q, ld_inflight_d;
    logic        ld_we_q, ld_we_d;
    logic        hold_v_q, hold_v_d;
    logic [63:0] hold_data_q, hold_data_d;

    logic        fetch_elig;
    logic        fetch_gnt;
    logic        ld_gnt;
    logic        ld_wr;
    logic        fetch_rvalid;
    logic        ld_rvalid;

    // A fetch may not issue while a previous response is still undelivered.
    always_comb begin
        fetch_elig = bus.fetch_req & ~bus.flush & ~hold_v_q
                   & ~(fetch_inflight_q & ~bus.fetch_rready) & ~rst_i;
        fetch_gnt  = fetch_elig & (~bus.ld_req | (starve_q == c_MAXWAIT));
        ld_gnt     = bus.ld_req & ~fetch_gnt & ~rst_i;
        ld_wr      = ld_gnt & bus.ld_we;
    end

    always_comb begin
        bus.fetch_gnt = fetch_gnt;
        bus.ld_gnt    = ld_gnt;
        bus.ram_en    = fetch_gnt | ld_gnt;
        bus.ram_we    = ld_wr;
        bus.ram_wstrb = ld_wr ? bus.ld_wstrb : 8'h00;
        bus.ram_wdata = ld_wr ? bus.ld_wdata : 64'h0;
        if (fetch_gnt) begin
            bus.ram_addr = bus.fetch_addr;
        end else if (ld_gnt) begin
            bus.ram_addr = bus.ld_addr;
        end else begin
            bus.ram_addr = '0;
        end
    end

    always_comb begin
        fetch_rvalid     = ~rst_i & ~bus.flush & (hold_v_q | fetch_inflight_q);
        ld_rvalid        = ~rst_i & ld_inflight_q;
        bus.fetch_rvalid = fetch_rvalid;
        bus.ld_rvalid    = ld_rvalid;
        if (!fetch_rvalid) begin
            bus.fetch_rdata = 64'h0;
        end else if (hold_v_q) begin
            bus.fetch_rdata = hold_data_q;
        end else begin
            bus.fetch_rdata = bus.ram_rdata;
        end
        bus.ld_rdata = (ld_rvalid & ~ld_we_q) ? bus.ram_rdata : 64'h0;
    end

    always_comb begin
        if (bus.fetch_req & ~fetch_gnt) begin
            starve_d = (starve_q >= c_MAXWAIT) ? c_MAXWAIT : starve_q + 3'd1;
        end else begin
            starve_d = 3'd0;
        end
        fetch_inflight_d = fetch_gnt;
        ld_inflight_d    = ld_gnt;
        ld_we_d          = ld_wr;

        // RAM data is only present for one cycle, so a refused response is parked.
        hold_v_d    = hold_v_q;
        hold_data_d = hold_data_q;
        if (bus.flush) begin
            hold_v_d = 1'b0;
        end else if (hold_v_q) begin
            if (bus.fetch_rready) begin
                hold_v_d = 1'b0;
            end
        end else if (fetch_inflight_q & ~bus.fetch_rready) begin
            hold_v_d    = 1'b1;
            hold_data_d = bus.ram_rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q         <= 3'd0;
            fetch_inflight_q <= 1'b0;
            ld_inflight_q    <= 1'b0;
            ld_we_q          <= 1'b0;
            hold_v_q         <= 1'b0;
            hold_data_q      <= 64'h0;
        end else begin
            starve_q         <= starve_d;
            fetch_inflight_q <= fetch_inflight_d;
            ld_inflight_q    <= ld_inflight_d;
            ld_we_q          <= ld_we_d;
            hold_v_q         <= hold_v_d;
            hold_data_q      <= hold_data_d;
        end
    end
endmodule
`default_nettype wire

// File: doc/itcm_arbiter.md
ITCM_ARBITER -- requirements
Module: itcm_arbiter

Interface
REQ-001 Parameter AW, 14: ITCM word-address width (2**14 words of 64 bits).
REQ-002 Parameter MAXWAIT, 4: cycles a pending fetch request may be refused before it wins priority.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 fetch_req  in  1  fetch unit requests a 64-bit instruction read.
REQ-006 fetch_addr  in  AW  fetch word address.
REQ-007 fetch_gnt  out  1  fetch request accepted this cycle (combinational).
REQ-008 fetch_rvalid  out  1  fetch read data valid.
REQ-009 fetch_rdata  out  64  fetch read data.
REQ-010 fetch_rready  in  1  fetch consumer can accept data (low while instruction FIFO full).
REQ-011 flush  in  1  front-end redirect; discards all fetch responses not yet delivered.
REQ-012 ld_req / ld_we  in  1 / 1  loader access request / write enable.
REQ-013 ld_addr / ld_wdata / ld_wstrb  in  AW / 64 / 8  loader address, write data, byte strobes.
REQ-014 ld_gnt / ld_rvalid  out  1 / 1  loader accepted / loader response (read data or write ack).
REQ-015 ld_rdata  out  64  loader read data.
REQ-016 ram_en / ram_we / ram_wstrb  out  1 / 1 / 8  single-port ITCM control.
REQ-017 ram_addr / ram_wdata  out  AW / 64  ITCM address and write data.
REQ-018 ram_rdata  in  64  ITCM read data, valid cycle after ram_en with ram_we low.

Function
REQ-019 At most one of fetch_gnt, ld_gnt SHALL be high per cycle; ram_en = fetch_gnt | ld_gnt; ram_* driven from the granted requester in the same cycle.
REQ-020 fetch_gnt SHALL only be asserted to a fetch_req; ram_we and ram_wstrb SHALL be 0 on fetch grants.
REQ-021 Fetch eligibility: fetch_req & ~flush & ~hold_v & ~(fetch_inflight & ~fetch_rready).
REQ-022 Priority: loader wins when ld_req high, unless starve counter == MAXWAIT and fetch is eligible, then fetch wins.
REQ-023 Starve counter (3 bits, saturating at MAXWAIT) SHALL increment each cycle fetch_req is high and fetch_gnt low, and clear on fetch_gnt or fetch_req low.
REQ-024 Response latency: exactly 1 cycle; grant in cycle N gives rvalid in cycle N+1 for the same requester.
REQ-025 Fetch response in cycle N+1: fetch_rvalid=1, fetch_rdata=ram_rdata; if fetch_rready low, data SHALL be captured into a 1-entry hold buffer (hold_v=1).
REQ-026 While hold_v: fetch_rvalid=1, fetch_rdata=buffer; hold_v clears on the cycle fetch_rready is high.
REQ-027 Flush cycle: fetch_rvalid SHALL be 0, in-flight fetch response and hold buffer discarded, fetch_gnt 0; loader traffic unaffected.
REQ-028 Loader read: ld_rvalid=1, ld_rdata=ram_rdata in N+1; loader write: ld_rvalid=1, ld_rdata=0 in N+1, byte lanes with ld_wstrb=0 unchanged.
REQ-029 Loader has no backpressure; ld_rvalid is a single-cycle pulse.
REQ-030 Back-to-back fetch grants SHALL sustain one per cycle while fetch_rready stays high and no loader request.

Reset
REQ-031 With RST high at a clock edge: starve counter 0, hold_v 0, in-flight flags 0; all outputs 0 the following cycle.
REQ-032 Reset asserted with a grant outstanding SHALL drop that response (no rvalid after reset).
REQ-033 Grants SHALL remain 0 during any cycle RST is high.

Verification
REQ-034 Fetch only, addr 0x000..0x003 on consecutive cycles, rready=1 -> fetch_rvalid 4 consecutive cycles, data = RAM words 0..3 in order.
REQ-035 Loader write addr 0x010 data 0x1122334455667788 wstrb 0x0F, then read 0x010 (prior 0) -> ld_rdata 0x0000000055667788.
REQ-036 ld_req and fetch_req held high continuously -> loader granted 4 cycles, fetch granted cycle 5, counter returns to 0, pattern repeats.
REQ-037 Fetch grant at addr 0x020, fetch_rready low 3 cycles -> fetch_rvalid high 3 cycles with constant word 0x020 data, no new fetch_gnt, released when rready high.
REQ-038 Fetch grant at cycle N, flush at N+1 -> fetch_rvalid 0 at N+1, no stale data later; next fetch at N+2 returns correct new address data.
REQ-039 RST pulsed one cycle after loader read grant -> no ld_rvalid, all outputs 0, normal operation after RST low.
